// File: rtl/button_debounce_pkg.sv
// Shared types for the push-button debouncer: FSM state encoding and counter width.
package button_pkg;
    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;
endpackage

// File: rtl/button_debounce_sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
// On reset both flops load RST_VAL, so the pin's idle level can be chosen.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronized pin, stable-count acceptance, press/release pulses.
// Optional long-press pulse when LONG_PRESS_EN is defined; otherwise long_pulse is tied 0.
//
// state        | meaning
// RELEASED     | button accepted as released
// PRESS_WAIT   | pressed seen, counting stable cycles
// PRESSED      | button accepted as pressed (hold count when long press is enabled)
// RELEASE_WAIT | released seen, counting stable cycles
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned LONG_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    btn_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             sync_q, pressed_s;
    logic             level_nxt, press_nxt, release_nxt;

    // Flops reset to the not-pressed pin level so reset never looks like a press.
    sync_2ff #(.RST_VAL(ACTIVE_LOW)) u_sync_btn (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_raw),
        .q    (sync_q)
    );

    assign pressed_s = sync_q ^ ACTIVE_LOW;
    // Saturating increment; the debounce waits never get near the ceiling.
    assign cnt_inc   = (cnt == LONG_LAST) ? cnt : cnt + CNT_ONE;

`ifdef LONG_PRESS_EN
    logic long_done, long_done_nxt, long_nxt;
`endif

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        level_nxt   = btn_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
`ifdef LONG_PRESS_EN
        long_nxt      = 1'b0;
        long_done_nxt = long_done;
`endif
        case (state)
            RELEASED: begin
                if (pressed_s) begin
                    state_nxt = PRESS_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_nxt = RELEASED;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            PRESSED: begin
                if (!pressed_s) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_ONE;
                end else begin
`ifdef LONG_PRESS_EN
                    cnt_nxt = cnt_inc;
                    if (cnt == LONG_LAST - CNT_ONE && !long_done) begin
                        long_nxt      = 1'b1;
                        long_done_nxt = 1'b1;
                    end
`endif
                end
            end
            RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_nxt = PRESSED;
                    cnt_nxt   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nxt   = RELEASED;
                    cnt_nxt     = '0;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
`ifdef LONG_PRESS_EN
                    long_done_nxt = 1'b0;
`endif
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = RELEASED;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= RELEASED;
            cnt           <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            btn_level     <= level_nxt;
            press_pulse   <= press_nxt;
            release_pulse <= release_nxt;
        end
    end

`ifdef LONG_PRESS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            long_done  <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            long_done  <= long_done_nxt;
            long_pulse <= long_nxt;
        end
    end
`else
    assign long_pulse = 1'b0;
`endif
endmodule
